// File: rtl/x_line_buffer_pkg.sv
// Shared helpers for the X line buffer: derived sizes and modulo slot-pointer arithmetic.
// Slot pointers live in 0..K, so every increment wraps explicitly at K+1.
package x_line_buffer_pkg;

   function automatic int pad_of(input int k);
      return (k - 1) / 2;
   endfunction

   function automatic int words_of(input int row_pix, input int pix_per_load);
      return row_pix / pix_per_load;
   endfunction

   function automatic int slot_w_of(input int k);
      return (k + 1 > 1) ? $clog2(k + 1) : 1;
   endfunction

   function automatic int min_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // a and b are both already below m, so one conditional subtract suffices.
   function automatic int unsigned slot_add(input int unsigned a, input int unsigned b,
                                            input int unsigned m);
      int unsigned s;
      s = a + b;
      return (s >= m) ? s - m : s;
   endfunction

   function automatic int unsigned slot_inc(input int unsigned a, input int unsigned m);
      return slot_add(a, 1, m);
   endfunction

endpackage

// File: rtl/xbuf_tap_mux.sv
// Picks K consecutive pixels centred on col from one row, with zeros past either row edge.
module xbuf_tap_mux
   import x_line_buffer_pkg::*;
#(
   parameter int PIX_W   = 8,
   parameter int ROW_PIX = 28,
   parameter int K       = 3,
   parameter int COL_W   = 5
) (
   input  logic [ROW_PIX*PIX_W-1:0] row,
   input  logic [COL_W-1:0]         col,
   output logic [K*PIX_W-1:0]       taps
);

   localparam int PAD = pad_of(K);

   int idx;

   always_comb begin
      taps = '0;
      idx  = 0;
      for (int c = 0; c < K; c++) begin
         idx = int'(col) - PAD + c;
         if (idx >= 0 && idx < ROW_PIX)
            taps[c*PIX_W +: PIX_W] = row[idx*PIX_W +: PIX_W];
      end
   end

endmodule

// File: rtl/x_line_buffer.sv
// K+1 row slots in a ring: K rows feed a KxK sliding window while the spare slot loads.
// Window stepping and row loading proceed independently; row_advance retires the oldest row.
module x_line_buffer
   import x_line_buffer_pkg::*;
#(
   parameter int PIX_W        = 8,
   parameter int PIX_PER_LOAD = 4,
   parameter int LOAD_W       = 32,
   parameter int ROW_PIX      = 28,
   parameter int K            = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 load_valid,
   output logic                 load_ready,
   input  logic [LOAD_W-1:0]    load_data,
   output logic                 load_done,
   input  logic                 shift_en,
   input  logic                 row_advance,
   output logic                 win_valid,
   output logic [K*K*PIX_W-1:0] win_out,
   output logic                 row_end,
   output logic                 adv_err
);

   localparam int WPR    = words_of(ROW_PIX, PIX_PER_LOAD);
   localparam int SLOT_W = slot_w_of(K);
   localparam int FILL_W = slot_w_of(K);
   localparam int COL_W  = min_w(ROW_PIX);
   localparam int WC_W   = min_w(WPR);
   localparam int ROW_W  = ROW_PIX * PIX_W;
   localparam int TAPS_W = K * PIX_W;

   logic [ROW_W-1:0]  row_mem [K+1];
   logic [SLOT_W-1:0] base;
   logic [FILL_W-1:0] fill_cnt;
   logic [WC_W-1:0]   word_cnt;
   logic [COL_W-1:0]  col;
   logic              load_done_q;
   logic              win_valid_q;
   logic              adv_err_q;

   logic              priming;
   logic [SLOT_W-1:0] ld_slot;
   logic              load_fire;
   logic              last_word;
   logic              at_last_col;
   logic              adv_legal;
   logic              shift_ok;

   assign priming     = fill_cnt < FILL_W'(K);
   assign ld_slot     = SLOT_W'(slot_add(32'(base), priming ? 32'(fill_cnt) : 32'(K), K + 1));
   assign load_ready  = !load_done_q;
   assign load_fire   = load_valid && load_ready && !flush;
   assign last_word   = word_cnt == WC_W'(WPR - 1);
   assign at_last_col = col == COL_W'(ROW_PIX - 1);
   assign row_end     = win_valid_q && at_last_col;
   assign adv_legal   = row_advance && row_end && load_done_q;
   assign shift_ok    = shift_en && win_valid_q && !at_last_col && !adv_legal;

   assign load_done   = load_done_q;
   assign win_valid   = win_valid_q;
   assign adv_err     = adv_err_q;

   // Row contents survive flush; only reset clears them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s <= K; s++)
            row_mem[s] <= '0;
      end else if (load_fire) begin
         row_mem[ld_slot][word_cnt*LOAD_W +: LOAD_W] <= load_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         base        <= '0;
         fill_cnt    <= '0;
         word_cnt    <= '0;
         col         <= '0;
         load_done_q <= 1'b0;
         win_valid_q <= 1'b0;
         adv_err_q   <= 1'b0;
      end else if (flush) begin
         base        <= '0;
         fill_cnt    <= '0;
         word_cnt    <= '0;
         col         <= '0;
         load_done_q <= 1'b0;
         win_valid_q <= 1'b0;
         adv_err_q   <= 1'b0;
      end else begin
         if (load_fire) begin
            if (last_word) begin
               word_cnt <= '0;
               if (priming) begin
                  fill_cnt <= fill_cnt + 1'b1;
                  if (fill_cnt == FILL_W'(K - 1))
                     win_valid_q <= 1'b1;
               end else begin
                  load_done_q <= 1'b1;
               end
            end else begin
               word_cnt <= word_cnt + 1'b1;
            end
         end
         // A legal advance never overlaps a load: load_ready is low whenever load_done is set.
         if (row_advance) begin
            if (adv_legal) begin
               base        <= SLOT_W'(slot_inc(32'(base), K + 1));
               col         <= '0;
               load_done_q <= 1'b0;
               word_cnt    <= '0;
            end else begin
               adv_err_q   <= 1'b1;
            end
         end
         if (shift_ok)
            col <= col + 1'b1;
      end
   end

   logic [TAPS_W-1:0] row_taps [K];

   for (genvar r = 0; r < K; r++) begin : g_row
      logic [SLOT_W-1:0] sel;
      assign sel = SLOT_W'(slot_add(32'(base), r, K + 1));

      xbuf_tap_mux #(
         .PIX_W   (PIX_W),
         .ROW_PIX (ROW_PIX),
         .K       (K),
         .COL_W   (COL_W)
      ) u_tap_mux (
         .row  (row_mem[sel]),
         .col  (col),
         .taps (row_taps[r])
      );
   end

   always_comb begin
      win_out = '0;
      if (win_valid_q) begin
         for (int r = 0; r < K; r++)
            win_out[r*TAPS_W +: TAPS_W] = row_taps[r];
      end
   end

endmodule

// File: doc/x_line_buffer.md
Name: x_line_buffer

Overview:
Parametrised successor to the X input buffer in the matrix/conv datapath. Holds K+1 row slots in a ring: K active rows feed a KxK sliding window to the ALU while the spare slot loads the next row from the APB-side loader. Load and window stepping run concurrently. Column selection is pointer-based, with zero padding at the row edges.

Parameters:
PIX_W, 8, bits per pixel
PIX_PER_LOAD, 4, pixels per load word
LOAD_W, 32, load word width; must equal PIX_W*PIX_PER_LOAD
ROW_PIX, 28, pixels per row; must be a multiple of PIX_PER_LOAD
K, 3, window size; odd, >=3; PAD=(K-1)/2

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
flush  in  1  sync clear of pointers, counters and flags
load_valid  in  1  load word offered
load_ready  out  1  buffer accepts word
load_data  in  LOAD_W  pixels; lowest pixel index in bits [PIX_W-1:0]
load_done  out  1  level: spare slot fully loaded
shift_en  in  1  advance window one column
row_advance  in  1  retire oldest row, promote spare
win_valid  out  1  K rows primed; win_out meaningful
win_out  out  K*K*PIX_W  window taps
row_end  out  1  col==ROW_PIX-1
adv_err  out  1  sticky: illegal row_advance seen

Behaviour:
- Reset (rst=0, async): all row slots=0, base=0, fill_cnt=0, word_cnt=0, col=0, load_done=0, win_valid=0, adv_err=0, load_ready=1, win_out=0.
- flush: same as reset except row contents are kept; it is synchronous and has priority over all other inputs.
- Load transfer occurs when load_valid&&load_ready. Word w writes pixels PIX_PER_LOAD*w.. of slot ld_slot. word_cnt counts 0..ROW_PIX/PIX_PER_LOAD-1.
- Priming (fill_cnt<K): ld_slot=(base+fill_cnt) mod (K+1). On the last word, fill_cnt++ and word_cnt=0 in the same cycle, with no stall. win_valid=1 from the cycle after fill_cnt reaches K.
- Steady state (fill_cnt==K): ld_slot=(base+K) mod (K+1). The last word sets load_done=1. load_ready = !load_done.
- shift_en is honoured only when win_valid && col<ROW_PIX-1, and then col++. It is ignored otherwise. It never stalls loading.
- row_end = win_valid && col==ROW_PIX-1.
- row_advance is legal only when row_end && load_done. If legal: base=(base+1) mod (K+1), col=0, load_done=0, word_cnt=0, and load_ready rises the next cycle. If illegal: no state change, and adv_err=1 until rst or flush.
- Simultaneous events:
  - row_advance and shift_en: advance wins, col=0.
  - Load and shift in the same cycle: both take effect.
  - A load cannot coincide with a legal advance, because load_ready=0 when load_done=1.
- win_out is combinational from registers, with zero latency.
  - Tap (r,c) occupies bits [(r*K+c+1)*PIX_W-1 : (r*K+c)*PIX_W].
  - r=0 is the oldest row (slot base); r=K-1 is the newest.
  - Tap (r,c) holds pixel col-PAD+c of row r. Out-of-range pixel indices give 0.
  - win_out=0 while win_valid=0.
- Widths:
  - slot index: clog2(K+1)
  - col: clog2(ROW_PIX)
  - word_cnt: clog2(ROW_PIX/PIX_PER_LOAD)
  - fill_cnt: clog2(K+1)
  - All pointer arithmetic is modulo K+1. Do not use natural wrap, because K+1 need not be a power of two.

Decomposition:
- Shared package or header: PAD, WORDS_PER_ROW, clog2 widths, and the slot-index modulo-increment function.
- One sub-module, xbuf_tap_mux: given one row (ROW_PIX*PIX_W) and col, it outputs K zero-padded taps. Instantiate it K times, once per active row, selected via (base+r) mod (K+1).

Test Plan:
Defaults K=3, ROW_PIX=8, PIX_PER_LOAD=4 (2 words/row), PIX_W=8. Row r pixel p = 16r+p.
1. Reset: release rst -> load_ready=1, win_valid=0, load_done=0, win_out=0, adv_err=0.
2. Prime: load 6 words for rows 0..2 back-to-back -> load_ready stays 1; win_valid=1; load_done=0; row0 taps=(0x00,0x00,0x01), row2 taps=(0x00,0x20,0x21).
3. Shift 7x -> col=7, row_end=1, row0 taps=(0x06,0x07,0x00). An 8th shift_en leaves win_out unchanged.
4. Load row 3 interleaved with shifts -> after 2nd word load_done=1, load_ready=0. Then row_advance at row_end -> col=0, taps row0=(0,0x10,0x11), row2=(0,0x30,0x31), load_ready=1.
5. row_advance at col=3, or with load_done=0 -> window unchanged, adv_err=1 and held. Then flush -> adv_err=0, win_valid=0, load_ready=1.
6. Assert rst after 1 word of row 1 -> all outputs return to reset values immediately. Repeating scenario 2 then gives the identical result.
